// File: rtl/buffer_pkg.sv
// Shared types and widths for the channelised buffer read path.
package buffer_pkg;

    localparam int unsigned NUM_CH     = 4;
    localparam int unsigned CH_W       = 2;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned ARB_CNT_W  = 4;
    localparam int unsigned DEF_DATA_W = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [CH_W-1:0]       ch;
        logic [DEF_DATA_W-1:0] payload;
    } entry_t;

endpackage

// File: rtl/rr_burst_arbiter.sv
// Round-robin channel arbiter that lets the current owner keep up to BURST consecutive grants.
module rr_burst_arbiter
    import buffer_pkg::*;
#(
    parameter int unsigned BURST = 2
) (
    input  logic [NUM_CH-1:0]    req_i,
    input  logic [CH_W-1:0]      owner_i,
    input  logic [ARB_CNT_W-1:0] cnt_i,
    output logic [CH_W-1:0]      gnt_idx_o,
    output logic                 gnt_vld_o
);

    logic [CH_W-1:0] cand;
    logic            found;

    // Owner keeps the grant while under budget; otherwise search starting just after it.
    always_comb begin
        gnt_idx_o = owner_i;
        cand      = owner_i;
        found     = 1'b0;
        if (req_i[owner_i] && (cnt_i < ARB_CNT_W'(BURST))) begin
            found = 1'b1;
        end
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            cand = owner_i + CH_W'(k);
            if (!found && req_i[cand]) begin
                gnt_idx_o = cand;
                found     = 1'b1;
            end
        end
    end

    assign gnt_vld_o = |req_i;

endmodule

// File: rtl/buffer_reader.sv
// Drains four per-channel buffers onto one valid/ready stream of {channel, payload} words.
// Optional per-channel accept counters are built when READER_STATS_EN is defined.
module buffer_reader
    import buffer_pkg::*;
#(
    parameter int unsigned DATA_W = 2,
    parameter int unsigned BURST  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          buf_valid_i,
    input  logic [NUM_CH*DATA_W-1:0]   buf_data_i,
    output logic [NUM_CH-1:0]          buf_pop_o,
    output logic                       out_valid_o,
    output logic [CH_W+DATA_W-1:0]     out_data_o,
    input  logic                       out_ready_i,
    input  logic                       flush_i,
    output logic [NUM_CH*CNT_W-1:0]    rd_count_o
);

    typedef struct packed {
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] payload;
    } out_entry_t;

    state_e                state_q, state_d;
    out_entry_t            data_q, data_d;
    logic [CH_W-1:0]       owner_q, owner_d;
    logic [ARB_CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_W-1:0]       gnt_idx;
    logic                  gnt_vld;
    logic                  load;

    rr_burst_arbiter #(
        .BURST (BURST)
    ) u_arb (
        .req_i     (buf_valid_i),
        .owner_i   (owner_q),
        .cnt_i     (cnt_q),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Flush wins over both load and accept.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else if (load) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && out_ready_i) begin
            state_d = ST_EMPTY;
        end
    end

    // Load decode, pop strobe and next output/arbitration values; rst_n gates the pop so it drops immediately.
    always_comb begin
        load      = rst_n && !flush_i && gnt_vld && ((state_q == ST_EMPTY) || out_ready_i);
        buf_pop_o = '0;
        data_d    = data_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        if (load) begin
            buf_pop_o[gnt_idx] = 1'b1;
            data_d.ch          = gnt_idx;
            data_d.payload     = buf_data_i[gnt_idx*DATA_W +: DATA_W];
            if (gnt_idx == owner_q) begin
                if (cnt_q < ARB_CNT_W'(BURST)) begin
                    cnt_d = cnt_q + ARB_CNT_W'(1);
                end
            end else begin
                owner_d = gnt_idx;
                cnt_d   = ARB_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            owner_q <= CH_W'(NUM_CH - 1);
            cnt_q   <= ARB_CNT_W'(BURST);
        end else begin
            data_q  <= data_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_o = (state_q == ST_FULL);
    assign out_data_o  = data_q;

`ifdef READER_STATS_EN
    logic [NUM_CH-1:0][CNT_W-1:0] rd_cnt_q;

    // Counts accepted words per channel; flush does not touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
        end else if (out_valid_o && out_ready_i) begin
            rd_cnt_q[data_q.ch] <= rd_cnt_q[data_q.ch] + CNT_W'(1);
        end
    end

    assign rd_count_o = rd_cnt_q;
`else
    assign rd_count_o = '0;
`endif

endmodule

// File: tb/tb_buffer_reader.sv
// Directed bench for buffer_reader with a queue-based buffer model and a history-based arbitration model.
module tb_buffer_reader;

    localparam int DATA_W = 2;
    localparam int BURST  = 2;
    localparam int NCH    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NCH-1:0]      buf_valid;
    logic [NCH*DATA_W-1:0] buf_data;
    logic [NCH-1:0]      buf_pop;
    logic                out_valid;
    logic [1+DATA_W:0]   out_data;
    logic                out_ready;
    logic                flush;
    logic [NCH*8-1:0]    rd_count;

    always #5 clk = ~clk;

    buffer_reader #(
        .DATA_W (DATA_W),
        .BURST  (BURST)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .buf_valid_i (buf_valid),
        .buf_data_i  (buf_data),
        .buf_pop_o   (buf_pop),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_ready_i (out_ready),
        .flush_i     (flush),
        .rd_count_o  (rd_count)
    );

    logic [DATA_W-1:0] q0[$], q1[$], q2[$], q3[$];
    int                hist[$];
    logic              mvalid;
    logic [1+DATA_W:0] mdata;
    int                mcount[NCH];
    bit                chk_en = 1'b0;
    int                n_pass = 0;
    int                n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int qsize(input int c);
        case (c)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] qhead(input int c);
        if (qsize(c) == 0) return '0;
        case (c)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic qpush(input int c, input logic [DATA_W-1:0] v);
        case (c)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endtask

    task automatic qpop(input int c);
        case (c)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic drive_bufs();
        for (int c = 0; c < NCH; c++) begin
            buf_valid[c] = (qsize(c) > 0);
            buf_data[c*DATA_W +: DATA_W] = qhead(c);
        end
    endtask

    // Grant from the run length of the most recent grants; empty history acts as a spent run on channel 3.
    function automatic int model_grant();
        int last;
        int run;
        if (hist.size() == 0) begin
            last = NCH - 1;
            run  = BURST;
        end else begin
            last = hist[hist.size()-1];
            run  = 0;
            for (int i = hist.size() - 1; i >= 0; i--) begin
                if (hist[i] != last) break;
                run++;
            end
        end
        if (qsize(last) > 0 && run < BURST) return last;
        for (int k = 1; k <= NCH; k++) begin
            if (qsize((last + k) % NCH) > 0) return (last + k) % NCH;
        end
        return -1;
    endfunction

    function automatic logic [NCH-1:0] model_pop();
        int g;
        model_pop = '0;
        if (!flush && (!mvalid || out_ready)) begin
            g = model_grant();
            if (g >= 0) model_pop = 4'(1) << g;
        end
    endfunction

    function automatic logic [31:0] exp_count();
        exp_count = '0;
`ifdef READER_STATS_EN
        for (int c = 0; c < NCH; c++) exp_count[c*8 +: 8] = 8'(mcount[c]);
`endif
    endfunction

    task automatic model_update();
        int g;
        g = -1;
        if (!flush && (!mvalid || out_ready)) g = model_grant();
        if (mvalid && out_ready) mcount[int'(mdata[1+DATA_W:DATA_W])] = (mcount[int'(mdata[1+DATA_W:DATA_W])] + 1) % 256;
        if (flush) begin
            mvalid = 1'b0;
        end else if (g >= 0) begin
            mvalid = 1'b1;
            mdata  = {2'(g), qhead(g)};
            qpop(g);
            hist.push_back(g);
        end else if (out_ready) begin
            mvalid = 1'b0;
        end
    endtask

    task automatic reset_model();
        mvalid = 1'b0;
        mdata  = '0;
        hist.delete();
        for (int c = 0; c < NCH; c++) mcount[c] = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_update();
        drive_bufs();
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        out_ready = 1'b0;
        flush  = 1'b0;
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        reset_model();
        drive_bufs();
        #2;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    // Per-cycle comparison against the model while outputs are meaningful.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("pop", 32'(buf_pop), 32'(model_pop()));
            chk("valid", 32'(out_valid), 32'(mvalid));
            if (mvalid) chk("data", 32'(out_data), 32'(mdata));
            chk("rd_count", rd_count, exp_count());
        end
    end

    initial begin
        int seq[9];
        seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        rst_n = 1'b0;
        out_ready = 1'b0;
        flush = 1'b0;
        buf_valid = '0;
        buf_data = '0;
        reset_model();
        drive_bufs();
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_pop", 32'(buf_pop), 32'd0);
        chk("rst_count", rd_count, 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step();

        // Single entry on channel 0
        qpush(0, 2'b10);
        out_ready = 1'b1;
        drive_bufs();
        @(negedge clk); chk("t1_pop", 32'(buf_pop), 32'b0001);
        step();
        @(negedge clk); chk("t1_valid", 32'(out_valid), 32'd1); chk("t1_data", 32'(out_data), 32'b0010);
        step();

        // All channels valid: burst-of-two round robin, no bubbles
        do_reset();
        for (int c = 0; c < NCH; c++)
            for (int i = 0; i < 3; i++) qpush(c, 2'(c + i));
        out_ready = 1'b1;
        drive_bufs();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk("t2_grant", 32'(buf_pop), 32'(4'(1) << seq[i]));
            if (i > 0) chk("t2_nobubble", 32'(out_valid), 32'd1);
            step();
        end

        // Back-pressure on channel 2
        do_reset();
        qpush(2, 2'b01);
        qpush(2, 2'b11);
        drive_bufs();
        @(negedge clk); chk("t3_first_pop", 32'(buf_pop), 32'b0100);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3_hold_data", 32'(out_data), 32'b1001);
            chk("t3_hold_pop", 32'(buf_pop), 32'd0);
            step();
        end
        out_ready = 1'b1;
        @(negedge clk); chk("t3_second_pop", 32'(buf_pop), 32'b0100);
        step();
        step();
        step();

        // Flush alongside out_ready with another channel waiting
        do_reset();
        qpush(0, 2'b01);
        drive_bufs();
        step();
        qpush(1, 2'b10);
        out_ready = 1'b1;
        flush = 1'b1;
        drive_bufs();
        @(negedge clk); chk("t4_flush_nopop", 32'(buf_pop), 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk); chk("t4_flushed", 32'(out_valid), 32'd0); chk("t4_reload_pop", 32'(buf_pop), 32'b0010);
        step();
        @(negedge clk); chk("t4_reload_data", 32'(out_data), 32'b0110);
        step();
        out_ready = 1'b0;

        // Asynchronous reset while FULL, then first grant restarts at channel 0
        qpush(2, 2'b11);
        qpush(0, 2'b00);
        qpush(3, 2'b01);
        drive_bufs();
        @(negedge clk); chk("t5_pop", 32'(buf_pop), 32'b0100);
        step();
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("t5_async_valid", 32'(out_valid), 32'd0);
        chk("t5_async_pop", 32'(buf_pop), 32'd0);
        chk("t5_async_count", rd_count, 32'd0);
        reset_model();
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk); chk("t5_first_grant", 32'(buf_pop), 32'b0001);
        step();
        out_ready = 1'b1;
        repeat (4) step();

        // 257 accepts from channel 3 wrap its counter to 1
        do_reset();
        for (int i = 0; i < 257; i++) qpush(3, 2'(i));
        out_ready = 1'b1;
        drive_bufs();
        repeat (259) step();
        @(negedge clk);
`ifdef READER_STATS_EN
        chk("t6_wrap", rd_count, 32'h0100_0000);
`else
        chk("t6_tied", rd_count, 32'd0);
`endif
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/buffer_reader.md
# buffer_reader

Read side of the channelised input buffers. Drains the four per-channel buffers filled by the input-capture block and re-serialises entries onto one valid/ready output stream. Output words use the capture format {channel[1:0], payload}. Channels are selected by round-robin arbitration with a bounded burst per channel.

## Interface
- DATA_W, default 2: payload width per buffer entry.
- BURST, default 2: maximum consecutive grants to one channel while others wait; legal range is 1 to 15.
- clk, input, 1: single clock; all state updates on its rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- buf_valid, input, 4: bit c high means the head of buffer c holds a valid entry.
- buf_data, input, 4*DATA_W: head payloads, channel c at bits [c*DATA_W +: DATA_W]; combinational from the buffer.
- buf_pop, output, 4: one-hot, single-cycle pulse that consumes the head of buffer c.
- out_valid, output, 1: output register holds an entry.
- out_data, output, 2+DATA_W: {channel, payload}.
- out_ready, input, 1: downstream accepts the entry when out_valid & out_ready.
- flush, input, 1: synchronous discard of the output register.
- rd_count, output, 4*8: per-channel accepted-entry counters, channel c at [c*8 +: 8].

## Operation
- FSM states:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1; out_data is held stable until accepted.
- Load condition: (state == EMPTY or out_ready) and |buf_valid and !flush.
  - On load: drive buf_pop[g] = 1 for the granted channel g, capture {g, head payload of g} into out_data, and go to (or stay in) FULL.
- FULL & out_ready with no load: go to EMPTY.
- flush: go to EMPTY and clear out_valid. No pop that cycle; the held entry is lost.
  - flush has priority over out_ready and over any load.
- Arbitration state: owner (2 bits) and cnt (4 bits).
  - If buf_valid[owner] and cnt < BURST: g = owner.
  - Otherwise g = the first c with buf_valid[c], searching owner+1, owner+2, owner+3, owner (mod 4).
  - On load: if g == owner, cnt <= cnt + 1; else owner <= g and cnt <= 1.
- buf_pop is never asserted without a load, and never for a channel whose buf_valid is low.
- Reset values: state EMPTY, out_valid 0, out_data 0, buf_pop 0, owner 3, cnt BURST (the first search starts at channel 0), rd_count all 0.

## Timing
- Latency: buf_valid rising in EMPTY gives out_valid the next cycle. buf_pop is asserted combinationally in the load cycle.
- Throughput: one entry per cycle while out_ready is held high and any buffer is non-empty.
- The buffer must drop the popped entry at the clock edge of the pop cycle; buf_valid and buf_data then reflect the new head.
- If out_valid is high and out_ready is low, out_data, owner and cnt are unchanged.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronously). The pending entry is lost, and buf_pop drops asynchronously.
- cnt saturates by construction: it never exceeds BURST, because owner changes once cnt reaches BURST.

## Configuration
- READER_STATS_EN defined:
  - rd_count[c] increments by 1 on each cycle with out_valid & out_ready & (out_data channel field == c).
  - Counters wrap from 255 to 0.
  - Counters are unaffected by flush; only rst_n clears them.
- READER_STATS_EN undefined: rd_count is tied to 0 and no counter flops are built.

## Structure
- Shared package `buffer_pkg`:
  - NUM_CH = 4
  - CH_W = 2
  - CNT_W = 8
  - the state enum {ST_EMPTY, ST_FULL}
  - the packed entry typedef {ch, payload}
- Sub-module `rr_burst_arbiter`: inputs req[3:0], owner, cnt and BURST; outputs grant index and grant-valid. Purely combinational.
- The top level holds the FSM, output register, owner/cnt update and the stats counters.

## Test plan
- Reset, then buf_valid = 4'b0001 with payload 2'b10 and out_ready = 1.
  - Required: buf_pop = 0001 on the first cycle; next cycle out_valid = 1 and out_data = 4'b0010.
- All four channels continuously valid, BURST = 2, out_ready = 1.
  - Required grant sequence: 0,0,1,1,2,2,3,3,0.
  - Required: one entry per cycle with no bubble.
- Channel 2 valid and out_ready held low for 5 cycles.
  - Required: exactly one pop; out_data is stable across all 5 cycles; the second pop occurs in the cycle out_ready rises.
- flush asserted in the same cycle as out_ready = 1 while another channel is valid.
  - Required: out_valid = 0 next cycle, no pop in the flush cycle, and the entry is reloaded one cycle later.
- rst_n pulsed low while FULL.
  - Required: out_valid, buf_pop and rd_count go to 0 without waiting for a clock edge, and the first grant after reset is channel 0.
- READER_STATS_EN defined, 257 accepts from channel 3.
  - Required: rd_count[3] = 1 and the other counters = 0.
